uart_frame_loader: RTL and testbench

//  Host-side front end of the neural-net datapath: assembles UART RX bytes into a command frame.

---
 rtl/uart_frame_loader.sv | 139 +++++++++++++
 tb/tb_uart_frame_loader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_loader.sv
// Assembles UART RX bytes (header, optional label, NPIX pixels[, XOR checksum if CHECKSUM_EN]) into a frame for the control unit.
// Latency: start/train pulse the cycle after the posedge accepting the last pixel (or checksum byte).
// Backpressure: none; bytes arriving in ISSUE/WAIT_ACK are dropped and flagged with a one-cycle overrun pulse.
module uart_frame_loader #(
    parameter int         NPIX         = 784,
    parameter logic [7:0] HDR_CLASSIFY = 8'hA5,
    parameter logic [7:0] HDR_TRAIN    = 8'h5A
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rx_valid,
    input  logic [7:0]          rx_data,
    input  logic                ack,
    output logic                start,
    output logic                train,
    output logic [7:0]          label_out,
    output logic [NPIX*8-1:0]   image_out,
    output logic                busy,
    output logic                frame_err,
    output logic                overrun
);

    localparam int            CW   = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam logic [CW-1:0] LAST = CW'(NPIX - 1);

`ifdef CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_LABEL, S_PIXELS, S_CSUM, S_ISSUE, S_WAIT_ACK
    } state_t;
    logic [7:0] csum;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_LABEL, S_PIXELS, S_ISSUE, S_WAIT_ACK
    } state_t;
`endif

    state_t        state;
    logic [CW-1:0] cnt;
    logic          is_train;

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            is_train  <= 1'b0;
            start     <= 1'b0;
            train     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            label_out <= '0;
            image_out <= '0;
`ifdef CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            start     <= 1'b0;
            train     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            case (state)
                S_IDLE: begin
`ifdef CHECKSUM_EN
                    csum <= rx_valid ? rx_data : 8'h00;
`endif
                    if (rx_valid) begin
                        if (rx_data == HDR_TRAIN) begin
                            state    <= S_LABEL;
                            is_train <= 1'b1;
                        end else if (rx_data == HDR_CLASSIFY) begin
                            state     <= S_PIXELS;
                            is_train  <= 1'b0;
                            label_out <= '0;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end
                S_LABEL: begin
                    if (rx_valid) begin
                        label_out <= rx_data;
                        state     <= S_PIXELS;
`ifdef CHECKSUM_EN
                        csum      <= csum ^ rx_data;
`endif
                    end
                end
                S_PIXELS: begin
                    if (rx_valid) begin
                        for (int k = 0; k < NPIX; k++) begin
                            if (cnt == CW'(k)) image_out[8*k +: 8] <= rx_data;
                        end
`ifdef CHECKSUM_EN
                        csum <= csum ^ rx_data;
`endif
                        if (cnt == LAST) begin
                            cnt <= '0;
`ifdef CHECKSUM_EN
                            state <= S_CSUM;
`else
                            state <= S_ISSUE;
                            start <= 1'b1;
                            train <= is_train;
`endif
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
`ifdef CHECKSUM_EN
                S_CSUM: begin
                    if (rx_valid) begin
                        if (rx_data == csum) begin
                            state <= S_ISSUE;
                            start <= 1'b1;
                            train <= is_train;
                        end else begin
                            state     <= S_IDLE;
                            frame_err <= 1'b1;
                        end
                    end
                end
`endif
                S_ISSUE: begin
                    // ack here is deliberately ignored; the control unit has not seen start yet
                    overrun <= rx_valid;
                    state   <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    overrun <= rx_valid;
                    if (ack) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_loader.sv
// Randomized and directed bench for uart_frame_loader (NPIX=4) against a byte-level frame model.
module tb_uart_frame_loader;
    localparam int NPIX = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              ack = 1'b0;
    logic              start, train, busy, frame_err, overrun;
    logic [7:0]        label_out;
    logic [NPIX*8-1:0] image_out;

    uart_frame_loader #(.NPIX(NPIX)) dut (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data), .ack(ack),
        .start(start), .train(train), .label_out(label_out), .image_out(image_out),
        .busy(busy), .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int n_start = 0, n_train = 0, n_err = 0, n_ovr = 0;
    int e_start = 0, e_train = 0, e_err = 0, e_ovr = 0;
    logic [7:0] m_img [NPIX];
    logic [7:0] m_label;
    logic [7:0] pix [NPIX];

    always @(negedge clk) begin
        if (start === 1'b1) n_start++;
        if (train === 1'b1) n_train++;
        if (frame_err === 1'b1) n_err++;
        if (overrun === 1'b1) n_ovr++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NPIX*8-1:0] model_img();
        logic [NPIX*8-1:0] r;
        for (int k = 0; k < NPIX; k++) r[8*k +: 8] = m_img[k];
        return r;
    endfunction

    // All tasks are entered and left at a negedge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_start", start, 0);
        check("rst_train", train, 0);
        check("rst_label", label_out, 0);
        check("rst_image", image_out, 0);
        check("rst_busy", busy, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_ovr", overrun, 0);
        for (int k = 0; k < NPIX; k++) m_img[k] = 8'h00;
        m_label = 8'h00;
        rst_n = 1'b1;
    endtask

    task automatic run_frame(input bit is_trn, input logic [7:0] lbl, input bit bad_csum,
                             input int gap, output bit issued);
        logic [7:0] hdr, x;
        hdr = is_trn ? 8'h5A : 8'hA5;
        send_byte(hdr, gap);
        x = hdr;
        check("busy_hdr", busy, 1);
        if (is_trn) begin
            send_byte(lbl, gap);
            x ^= lbl;
            m_label = lbl;
        end else begin
            m_label = 8'h00;
        end
        for (int k = 0; k < NPIX; k++) begin
            send_byte(pix[k], gap);
            x ^= pix[k];
            m_img[k] = pix[k];
            if (k < NPIX - 1) check("start_early", start, 0);
        end
`ifdef CHECKSUM_EN
        send_byte(bad_csum ? ~x : x, gap);
`endif
        check("label", label_out, m_label);
        check("image", image_out, model_img());
        issued = 1'b1;
`ifdef CHECKSUM_EN
        if (bad_csum) begin
            check("csum_err", frame_err, 1);
            check("csum_nostart", start, 0);
            check("csum_busy", busy, 0);
            e_err++;
            issued = 1'b0;
        end
`endif
        if (issued) begin
            check("start", start, 1);
            check("train", train, is_trn);
            e_start++;
            if (is_trn) e_train++;
        end
    endtask

    task automatic finish_frame(input bit early_ack, input bit issue_rx, input bit ovr,
                                input bit ack_rx, input int wait_cyc);
        logic [NPIX*8-1:0] img;
        img      = model_img();
        ack      = early_ack;
        rx_valid = issue_rx;
        rx_data  = 8'($urandom);
        @(negedge clk);
        ack      = 1'b0;
        rx_valid = 1'b0;
        check("start_1cyc", start, 0);
        check("busy_wait", busy, 1);
        check("ovr_issue", overrun, issue_rx);
        if (issue_rx) e_ovr++;
        repeat (wait_cyc) @(negedge clk);
        if (ovr) begin
            send_byte(8'hFF, 0);
            check("ovr_wait", overrun, 1);
            check("ovr_img", image_out, img);
            check("ovr_busy", busy, 1);
            e_ovr++;
        end
        ack      = 1'b1;
        rx_valid = ack_rx;
        rx_data  = 8'hA5;
        @(negedge clk);
        ack      = 1'b0;
        rx_valid = 1'b0;
        check("busy_ack", busy, 0);
        check("ovr_ack", overrun, ack_rx);
        if (ack_rx) e_ovr++;
        @(negedge clk);
        check("idle_after", busy, 0);
        check("img_hold", image_out, img);
    endtask

    task automatic bad_header(input logic [7:0] b);
        send_byte(b, 0);
        check("ferr", frame_err, 1);
        check("ferr_busy", busy, 0);
        check("ferr_nostart", start, 0);
        e_err++;
        @(negedge clk);
        check("ferr_1cyc", frame_err, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit         iss;
        logic [7:0] b;
        @(negedge clk);
        do_reset();

        // Classify frame
        pix = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_frame(1'b0, 8'h00, 1'b0, 0, iss);
        check("t1_image", image_out, 32'h04030201);
        finish_frame(1'b0, 1'b0, 1'b0, 1'b0, 3);

        // Train frame, with an overrun byte while waiting for ack
        pix = '{8'h10, 8'h20, 8'h30, 8'h40};
        run_frame(1'b1, 8'h07, 1'b0, 1, iss);
        check("t2_image", image_out, 32'h40302010);
        check("t2_label", label_out, 8'h07);
        finish_frame(1'b0, 1'b0, 1'b1, 1'b0, 2);

        // Bad header, then a good frame; ack together with rx_valid
        bad_header(8'h3C);
        pix = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_frame(1'b0, 8'h00, 1'b0, 0, iss);
        finish_frame(1'b1, 1'b0, 1'b0, 1'b1, 1);

        // ack in IDLE is ignored
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check("ack_idle", busy, 0);

        // Reset mid-frame
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        do_reset();
        pix = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};
        run_frame(1'b1, 8'h33, 1'b0, 0, iss);
        check("t5_image", image_out, 32'h0D0C0B0A);
        finish_frame(1'b0, 1'b1, 1'b0, 1'b0, 0);

`ifdef CHECKSUM_EN
        send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h02, 0);
        send_byte(8'h03, 0); send_byte(8'h04, 0); send_byte(8'hA1, 0);
        check("t6_start", start, 1);
        e_start++;
        for (int k = 0; k < NPIX; k++) m_img[k] = 8'(k + 1);
        m_label = 8'h00;
        finish_frame(1'b0, 1'b0, 1'b0, 1'b0, 0);
        send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h02, 0);
        send_byte(8'h03, 0); send_byte(8'h04, 0); send_byte(8'h00, 0);
        check("t6_err", frame_err, 1);
        check("t6_nostart", start, 0);
        e_err++;
`endif

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                do b = 8'($urandom); while (b == 8'hA5 || b == 8'h5A);
                bad_header(b);
            end else begin
                for (int k = 0; k < NPIX; k++) pix[k] = 8'($urandom);
                run_frame(1'($urandom), 8'($urandom), $urandom_range(0, 4) == 0,
                          $urandom_range(0, 2), iss);
                if (iss)
                    finish_frame(1'($urandom), 1'($urandom), 1'($urandom),
                                 1'($urandom), $urandom_range(0, 3));
            end
        end

        repeat (2) @(negedge clk);
        check("n_start", n_start, e_start);
        check("n_train", n_train, e_train);
        check("n_ferr", n_err, e_err);
        check("n_ovr", n_ovr, e_ovr);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
